// File: rtl/div_pkg.sv
// div_pkg: shared state encoding and sizing for the sequential divider.
package div_pkg;
  typedef enum logic [1:0] {IDLE, CALC, DONE} div_state_t;
  localparam int DIV_W = 32;
  localparam int CNT_W = $clog2(DIV_W);
endpackage

// File: rtl/div_step.sv
// div_step: one combinational radix-2 restoring division iteration.
module div_step #(
  parameter int W = 32
) (
  input  logic [W-1:0] rem,
  input  logic [W-1:0] q,
  input  logic [W-1:0] divisor_mag,
  output logic [W-1:0] rem_next,
  output logic [W-1:0] q_next
);
  logic [W:0] shifted, diff;
  // The full W+1-bit shifted remainder is kept so divisors above 2^(W-1) still work; diff MSB is the borrow.
  assign shifted = {rem, q[W-1]};
  assign diff = shifted - {1'b0, divisor_mag};
  assign rem_next = diff[W] ? shifted[W-1:0] : diff[W-1:0];
  assign q_next = {q[W-2:0], ~diff[W]};
endmodule

// File: rtl/seq_divider.sv
// seq_divider: iterative restoring divider for RV32M DIV/DIVU/REM/REMU.
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             is_signed,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);
  div_state_t state, next_state;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] rem, q, b_mag, rem_next, q_next, a_mag, d_mag;
  logic neg_q, neg_r, a_neg, b_neg, div_zero, overflow;
  assign a_neg = is_signed & dividend[WIDTH-1];
  assign b_neg = is_signed & divisor[WIDTH-1];
  assign a_mag = a_neg ? -dividend : dividend;
  assign d_mag = b_neg ? -divisor : divisor;
  assign div_zero = divisor == '0;
  assign overflow = is_signed && dividend == {1'b1, {(WIDTH-1){1'b0}}} && &divisor;
  assign busy = state == CALC;
  assign done = state == DONE;
  div_step #(.W(WIDTH)) u_step (
    .rem(rem),
    .q(q),
    .divisor_mag(b_mag),
    .rem_next(rem_next),
    .q_next(q_next)
  );
  always_comb begin
    next_state = state == IDLE ? (start ? ((div_zero | overflow) ? DONE : CALC) : IDLE) :
                 state == CALC ? (count == '0 ? DONE : CALC) : IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= next_state;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      rem <= '0;
      q <= '0;
      b_mag <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      quotient <= '0;
      remainder <= '0;
    end else if (state == IDLE && start) begin
      if (div_zero) begin
        quotient <= '1;
        remainder <= dividend;
      end else if (overflow) begin
        quotient <= dividend;
        remainder <= '0;
      end else begin
        count <= CNT_W'(WIDTH - 1);
        rem <= '0;
        q <= a_mag;
        b_mag <= d_mag;
        neg_q <= a_neg ^ b_neg;
        neg_r <= a_neg;
      end
    end else if (state == CALC) begin
      rem <= rem_next;
      q <= q_next;
      count <= count - 1'b1;
      if (count == '0) begin
        quotient <= neg_q ? -q_next : q_next;
        remainder <= neg_r ? -rem_next : rem_next;
      end
    end
  end
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed and random checks of seq_divider against an arithmetic model.
module tb_seq_divider;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, is_signed = 1'b0;
  logic [31:0] dividend = '0, divisor = '0;
  logic busy, done;
  logic [31:0] quotient, remainder;
  int n_assert = 0, n_fail = 0;

  seq_divider #(.WIDTH(32)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .dividend(dividend),
    .divisor(divisor),
    .is_signed(is_signed),
    .busy(busy),
    .done(done),
    .quotient(quotient),
    .remainder(remainder)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic s,
                                output logic [31:0] q, output logic [31:0] r, output logic sp);
    sp = (b == 0) || (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    if (b == 0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (sp) begin
      q = 32'h8000_0000;
      r = 0;
    end else if (s) begin
      q = 32'($signed(a) / $signed(b));
      r = 32'($signed(a) % $signed(b));
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s, input string tag);
    logic [31:0] eq, er;
    logic sp;
    int lat;
    model(a, b, s, eq, er, sp);
    @(negedge clk);
    dividend = a;
    divisor = b;
    is_signed = s;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    dividend = $urandom;
    divisor = $urandom;
    is_signed = $urandom_range(0, 1);
    chk({tag, " busy"}, {31'd0, busy}, {31'd0, !sp});
    lat = 1;
    while (!done && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({tag, " latency"}, lat, sp ? 1 : 33);
    chk({tag, " quotient"}, quotient, eq);
    chk({tag, " remainder"}, remainder, er);
    @(posedge clk);
    #1;
    chk({tag, " done pulse"}, {30'd0, done, busy}, 32'd0);
  endtask

  initial begin
    logic [31:0] a, b, eq, er, hq, hr;
    logic s, sp;
    int lat;
    #12;
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset done", {31'd0, done}, 32'd0);
    chk("reset quotient", quotient, 32'd0);
    chk("reset remainder", remainder, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op(32'd100, 32'd7, 1'b0, "divu 100/7");
    run_op(32'hFFFF_FFF9, 32'd2, 1'b1, "div -7/2");
    run_op(32'd5, 32'd0, 1'b1, "div 5/0");
    run_op(32'd5, 32'd0, 1'b0, "divu 5/0");
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, "div overflow");
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "divu 80000000/ffffffff");
    run_op(32'h8000_0000, 32'd3, 1'b1, "div min/3");
    run_op(32'hFFFF_FFFF, 32'h8000_0001, 1'b0, "divu big divisor");

    // Keep start high with fresh operands through CALC and DONE; only the first request may count.
    model(32'd1000, 32'd9, 1'b0, eq, er, sp);
    @(negedge clk);
    dividend = 32'd1000;
    divisor = 32'd9;
    is_signed = 1'b0;
    start = 1'b1;
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
      dividend = $urandom;
      divisor = $urandom_range(1, 50);
      is_signed = $urandom_range(0, 1);
    end while (!done && lat < 40);
    chk("restart latency", lat, 33);
    chk("restart quotient", quotient, eq);
    chk("restart remainder", remainder, er);
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("start in done ignored", {30'd0, done, busy}, 32'd0);
    run_op(32'd77, 32'd5, 1'b0, "after restart");

    @(negedge clk);
    dividend = 32'd1000;
    divisor = 32'd7;
    is_signed = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst busy", {31'd0, busy}, 32'd0);
    chk("midrst done", {31'd0, done}, 32'd0);
    chk("midrst quotient", quotient, 32'd0);
    chk("midrst remainder", remainder, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op(32'd9, 32'd3, 1'b0, "divu 9/3 after reset");

    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = $urandom_range(1, 16);
        2: b = 32'hFFFF_FFFF - $urandom_range(0, 3);
        3: b = a >> $urandom_range(0, 31);
        default: b = $urandom;
      endcase
      s = $urandom_range(0, 1);
      if (i % 13 == 0) begin
        a = 32'h8000_0000;
        b = 32'hFFFF_FFFF;
      end
      run_op(a, b, s, "random");
    end
    hq = quotient;
    hr = remainder;
    repeat (3) @(posedge clk);
    #1;
    chk("hold quotient", quotient, hq);
    chk("hold remainder", remainder, hr);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
